passcode_entry: RTL and testbench

- Upstream front-end for the access-control block: collects keypad digit strobes into a 4-digit BCD passcode.
- On an ENTER or CHANGE key, presents the passcode as a 16-bit word with a one-cycle load strobe and a 2-bit request code.
- Holds the request until the access-control block returns a non-zero status frame, then re-arms for the next entry.
- Also clears stale partial entries after an inactivity timeout.

---
 rtl/passcode_entry.sv | 157 +++++++++++++++
 tb/tb_passcode_entry.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/passcode_entry.sv
// Keypad front-end: gathers BCD digits and issues verify/change requests.
// Optional macro PASSCODE_SHORT_ENTRY_EN accepts entries shorter than DIGITS.
module passcode_entry #(
  parameter int DIGITS         = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            _Key_Code,
  input  logic                  _Key_Valid,
  input  logic [2:0]            _Status_Frame,
  output logic [4*DIGITS-1:0]   _Data_Out,
  output logic                  _Data_Out_Load,
  output logic [1:0]            _Request,
  output logic [2:0]            _Digit_Count,
  output logic                  _Entry_Error
);

  localparam int DW = 4 * DIGITS;
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t           state, state_n;
  logic [DW-1:0]    sreg, sreg_n;
  logic [DW-1:0]    dout_n;
  logic [2:0]       cnt, cnt_n;
  logic [CNT_W-1:0] tmr, tmr_n;
  logic [1:0]       req_n;
  logic             load_n;
  logic             err_n;

  logic is_digit;
  logic is_clear;
  logic is_go;
  logic key_ok;
  logic full;
  logic go_ok;

  assign is_digit = _Key_Valid && (_Key_Code <= 4'h9);
  assign is_clear = _Key_Valid && (_Key_Code == 4'hA);
  assign is_go    = _Key_Valid &&
                    ((_Key_Code == 4'hB) || (_Key_Code == 4'hC));
  assign key_ok   = is_digit || is_clear || is_go;
  assign full     = (cnt == 3'(DIGITS));

`ifdef PASSCODE_SHORT_ENTRY_EN
  assign go_ok = (cnt != 3'd0);
`else
  assign go_ok = full;
`endif

  assign _Digit_Count = cnt;

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    tmr_n   = tmr;
    dout_n  = _Data_Out;
    req_n   = _Request;
    load_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      S_IDLE, S_COLLECT: begin
        if (key_ok) begin
          tmr_n = '0;
          unique case (1'b1)
            is_digit: begin
              if (!full) begin
                sreg_n  = {sreg[DW-5:0], _Key_Code};
                cnt_n   = cnt + 3'd1;
                state_n = S_COLLECT;
              end else begin
                err_n = 1'b1;
              end
            end
            is_clear: begin
              sreg_n  = '0;
              cnt_n   = '0;
              state_n = S_IDLE;
            end
            is_go: begin
              if (go_ok) begin
                state_n = S_ISSUE;
                dout_n  = sreg;
                req_n   = (_Key_Code == 4'hB) ? 2'b01 : 2'b10;
                load_n  = 1'b1;
              end else begin
                err_n = 1'b1;
              end
            end
            default: ;
          endcase
        end else if (state == S_COLLECT) begin
          // stale partial entry is dropped silently
          if (tmr == T_LAST) begin
            sreg_n  = '0;
            cnt_n   = '0;
            tmr_n   = '0;
            state_n = S_IDLE;
          end else begin
            tmr_n = tmr + CNT_W'(1);
          end
        end else begin
          tmr_n = '0;
        end
      end
      S_ISSUE: begin
        state_n = S_WAIT;
        tmr_n   = '0;
      end
      S_WAIT: begin
        if ((_Status_Frame != 3'b000) || (tmr == T_LAST)) begin
          state_n = S_IDLE;
          sreg_n  = '0;
          cnt_n   = '0;
          tmr_n   = '0;
          dout_n  = '0;
          req_n   = 2'b00;
          err_n   = (_Status_Frame == 3'b000);
        end else begin
          tmr_n = tmr + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      sreg           <= '0;
      cnt            <= '0;
      tmr            <= '0;
      _Data_Out      <= '0;
      _Request       <= 2'b00;
      _Data_Out_Load <= 1'b0;
      _Entry_Error   <= 1'b0;
    end else begin
      state          <= state_n;
      sreg           <= sreg_n;
      cnt            <= cnt_n;
      tmr            <= tmr_n;
      _Data_Out      <= dout_n;
      _Request       <= req_n;
      _Data_Out_Load <= load_n;
      _Entry_Error   <= err_n;
    end
  end

endmodule

// File: tb/tb_passcode_entry.sv
// Directed plus randomized bench for passcode_entry.
// A digit-queue reference model predicts every registered output.
module tb_passcode_entry;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  kc  = 4'h0;
  logic        kv  = 1'b0;
  logic [2:0]  sf  = 3'b000;
  logic [15:0] dout;
  logic        load;
  logic [1:0]  req;
  logic [2:0]  dc;
  logic        err;

  int checks = 0;
  int errors = 0;

  int          q[$];
  int          phase = 0;
  int          age = 0;
  logic [15:0] m_dout = '0;
  logic [1:0]  m_req = '0;
  logic        m_load = 1'b0;
  logic        m_err = 1'b0;

  always #5 clk = ~clk;

  passcode_entry #(
    .DIGITS(4),
    .TIMEOUT_CYCLES(T),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    ._Key_Code(kc),
    ._Key_Valid(kv),
    ._Status_Frame(sf),
    ._Data_Out(dout),
    ._Data_Out_Load(load),
    ._Request(req),
    ._Digit_Count(dc),
    ._Entry_Error(err)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] qval();
    int v = 0;
    foreach (q[i]) v = v * 16 + q[i];
    return 16'(v);
  endfunction

  // phase: 0 = taking keys, 1 = request just issued, 2 = awaiting status
  task automatic model(input logic r, input logic v,
                       input logic [3:0] c, input logic [2:0] s);
    bit ok;
    m_load = 1'b0;
    m_err  = 1'b0;
    if (!r) begin
      q.delete();
      phase  = 0;
      age    = 0;
      m_dout = '0;
      m_req  = '0;
    end else if (phase == 1) begin
      phase = 2;
      age   = 0;
    end else if (phase == 2) begin
      if (s != 0 || age == T - 1) begin
        q.delete();
        m_dout = '0;
        m_req  = '0;
        m_err  = (s == 0);
        phase  = 0;
        age    = 0;
      end else begin
        age++;
      end
    end else if (v && c <= 4'hC) begin
      age = 0;
      if (c <= 4'h9) begin
        if (q.size() < 4) q.push_back(int'(c));
        else m_err = 1'b1;
      end else if (c == 4'hA) begin
        q.delete();
      end else begin
`ifdef PASSCODE_SHORT_ENTRY_EN
        ok = q.size() > 0;
`else
        ok = q.size() == 4;
`endif
        if (ok) begin
          m_dout = qval();
          m_req  = (c == 4'hB) ? 2'b01 : 2'b10;
          m_load = 1'b1;
          phase  = 1;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (q.size() > 0) begin
      if (age == T - 1) begin
        q.delete();
        age = 0;
      end else begin
        age++;
      end
    end
  endtask

  task automatic step(input logic r, input logic v,
                      input logic [3:0] c, input logic [2:0] s);
    @(negedge clk);
    rst = r;
    kv  = v;
    kc  = c;
    sf  = s;
    @(posedge clk);
    model(r, v, c, s);
    #1;
    chk("data_out", dout, m_dout);
    chk("request", {14'b0, req}, {14'b0, m_req});
    chk("load", {15'b0, load}, {15'b0, m_load});
    chk("error", {15'b0, err}, {15'b0, m_err});
    chk("digit_count", {13'b0, dc}, 16'(q.size()));
  endtask

  task automatic key(input logic [3:0] c);
    step(1'b1, 1'b1, c, 3'b000);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h0, 3'b000);
  endtask

  task automatic status(input logic [2:0] s);
    step(1'b1, 1'b0, 4'h0, s);
  endtask

  initial begin
    int errs;
    step(1'b0, 1'b0, 4'h0, 3'b000);
    step(1'b0, 1'b1, 4'hB, 3'b001);
    chk("rst_count", {13'b0, dc}, 16'h0);
    chk("rst_dout", dout, 16'h0);

    // basic verify
    for (int i = 1; i <= 4; i++) begin
      key(4'(i));
      chk("count_step", {13'b0, dc}, 16'(i));
    end
    key(4'hB);
    chk("enter_dout", dout, 16'h1234);
    chk("enter_req", {14'b0, req}, 16'h1);
    chk("enter_load", {15'b0, load}, 16'h1);
    idle(1);
    chk("load_one", {15'b0, load}, 16'h0);
    idle(1);
    status(3'b001);
    chk("resp_req", {14'b0, req}, 16'h0);
    chk("resp_dout", dout, 16'h0);
    chk("resp_count", {13'b0, dc}, 16'h0);

    // overflow digit then change
    key(4'h9); key(4'h8); key(4'h7); key(4'h6); key(4'h5);
    chk("ovf_err", {15'b0, err}, 16'h1);
    chk("ovf_count", {13'b0, dc}, 16'h4);
    key(4'hC);
    chk("chg_dout", dout, 16'h9876);
    chk("chg_req", {14'b0, req}, 16'h2);
    idle(1);
    status(3'b100);

    // short entry
    key(4'h4); key(4'h2); key(4'hB);
`ifdef PASSCODE_SHORT_ENTRY_EN
    chk("short_dout", dout, 16'h0042);
    chk("short_req", {14'b0, req}, 16'h1);
    idle(1);
    status(3'b010);
`else
    chk("short_err", {15'b0, err}, 16'h1);
    chk("short_count", {13'b0, dc}, 16'h2);
    key(4'hA);
`endif
    key(4'hB);
    chk("empty_err", {15'b0, err}, 16'h1);

    // inactivity timeout
    key(4'h5);
    idle(T);
    chk("idle_count", {13'b0, dc}, 16'h0);
    chk("idle_err", {15'b0, err}, 16'h0);
    key(4'h5);
    idle(T - 1);
    key(4'h5);
    chk("expiry_key", {13'b0, dc}, 16'h2);
    key(4'h1); key(4'h2); key(4'hB);
    chk("expiry_dout", dout, 16'h5512);
    idle(1);
    status(3'b111);

    // response timeout with keys ignored
    key(4'h2); key(4'h4); key(4'h6); key(4'h8); key(4'hB);
    errs = 0;
    for (int i = 0; i < T + 2; i++) begin
      key(4'(i % 10));
      if (err) errs++;
    end
    chk("wait_timeout_pulses", 16'(errs), 16'h1);
    key(4'hA);

    // reset during wait
    key(4'h1); key(4'h1); key(4'h1); key(4'h1); key(4'hB);
    idle(1);
    chk("wait_req", {14'b0, req}, 16'h1);
    step(1'b0, 1'b0, 4'h0, 3'b000);
    chk("wrst_req", {14'b0, req}, 16'h0);
    chk("wrst_dout", dout, 16'h0);
    key(4'h1);
    chk("wrst_key", {13'b0, dc}, 16'h1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic r;
      logic v;
      logic [3:0] c;
      logic [2:0] s;
      r = ($urandom_range(0, 199) != 0);
      v = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                      : 4'($urandom_range(0, 9));
      s = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      step(r, v, c, s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
